// File: rtl/upg_pkg.sv
// rtl/upg_pkg.sv - shared types and defaults for the UART program loader
//
// Purpose: state encodings for the loader FSM and the UART byte receiver,
//          plus default bit timing and ROM address width.
// Ports:   none (package).
package upg_pkg;

  // Loader FSM: length header, data words, then one of two terminal states.
  typedef enum logic [2:0] {
    LD_LEN_LO,
    LD_LEN_HI,
    LD_DATA,
    LD_DONE,
    LD_ERR
  } ld_state_t;

  // UART receiver.
  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_t;

  // 10 MHz / 115200 baud.
  localparam int UPG_CLKS_PER_BIT = 87;
  localparam int UPG_ADR_W        = 14;

endpackage

// File: rtl/uart_rx_byte.sv
// rtl/uart_rx_byte.sv - 8N1 UART byte receiver with start-bit glitch rejection
//
// Purpose: synchronizes the async line, samples each bit at its midpoint and
//          reports each completed frame as byte_vld (good stop bit) or
//          frm_err (stop bit low).
// Ports:
//   clk      in  - single clock
//   rst      in  - synchronous active-high reset
//   rx       in  - asynchronous UART line, idles high
//   byte_vld out - one-cycle strobe, byte_dat valid
//   byte_dat out - received byte, LSB arrived first
//   frm_err  out - one-cycle strobe on a low stop bit
module uart_rx_byte
  import upg_pkg::*;
#(
  parameter int CLKS_PER_BIT = UPG_CLKS_PER_BIT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic       byte_vld,
  output logic [7:0] byte_dat,
  output logic       frm_err
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic             rx_meta, rx_sync;
  rx_state_t        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       sh_q, sh_d;
  logic             vld_q, vld_d;
  logic             ferr_q, ferr_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      state_q <= RX_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      sh_q    <= '0;
      vld_q   <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      rx_meta <= rx;
      rx_sync <= rx_meta;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      sh_q    <= sh_d;
      vld_q   <= vld_d;
      ferr_q  <= ferr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    sh_d    = sh_q;
    vld_d   = 1'b0;
    ferr_d  = 1'b0;
    case (state_q)
      RX_IDLE: begin
        if (!rx_sync) begin
          state_d = RX_START;
          cnt_d   = '0;
        end
      end
      RX_START: begin
        if (cnt_q == HALF_LAST) begin
          // Line back high at mid start bit: treat the low as a glitch.
          cnt_d   = '0;
          bit_d   = '0;
          state_d = rx_sync ? RX_IDLE : RX_DATA;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RX_DATA: begin
        if (cnt_q == FULL_LAST) begin
          cnt_d = '0;
          sh_d  = {rx_sync, sh_q[7:1]};
          bit_d = bit_q + 1'b1;
          if (bit_q == 3'd7) state_d = RX_STOP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RX_STOP: begin
        if (cnt_q == FULL_LAST) begin
          // Back to IDLE at the stop sample so the next start edge is not missed.
          cnt_d   = '0;
          state_d = RX_IDLE;
          if (rx_sync) vld_d  = 1'b1;
          else         ferr_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = RX_IDLE;
    endcase
  end

  assign byte_vld = vld_q;
  assign byte_dat = sh_q;
  assign frm_err  = ferr_q;

endmodule

// File: rtl/uart_prog_loader.sv
// rtl/uart_prog_loader.sv - UART-fed program ROM loader
//
// Purpose: parses a 16-bit little-endian word count followed by that many
//          little-endian 32-bit words and issues one ROM write per word.
// Ports:
//   upg_clk_i  in  - UPG clock (single clock domain)
//   upg_rst_i  in  - synchronous active-high reset
//   upg_rx_i   in  - asynchronous UART line
//   upg_wen_o  out - one-cycle ROM write strobe
//   upg_adr_o  out - ROM word address, held between writes
//   upg_dat_o  out - ROM write data, held between writes
//   upg_done_o out - image fully written (sticky)
//   upg_err_o  out - protocol or framing error (sticky)
module uart_prog_loader
  import upg_pkg::*;
#(
  parameter int CLKS_PER_BIT = UPG_CLKS_PER_BIT,
  parameter int ADR_W        = UPG_ADR_W,
  parameter int MAX_WORDS    = 16384
) (
  input  logic             upg_clk_i,
  input  logic             upg_rst_i,
  input  logic             upg_rx_i,
  output logic             upg_wen_o,
  output logic [ADR_W-1:0] upg_adr_o,
  output logic [31:0]      upg_dat_o,
  output logic             upg_done_o,
  output logic             upg_err_o
);

  logic       byte_vld, frm_err;
  logic [7:0] byte_dat;

  uart_rx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
    .clk      (upg_clk_i),
    .rst      (upg_rst_i),
    .rx       (upg_rx_i),
    .byte_vld (byte_vld),
    .byte_dat (byte_dat),
    .frm_err  (frm_err)
  );

  ld_state_t        state_q, state_d;
  logic [15:0]      len_q, len_d;
  // One bit wider than the address so a full MAX_WORDS image never wraps.
  logic [ADR_W:0]   idx_q, idx_d;
  logic [1:0]       lane_q, lane_d;
  logic [23:0]      sh_q, sh_d;
  logic             wen_q, wen_d;
  logic [ADR_W-1:0] adr_q, adr_d;
  logic [31:0]      dat_q, dat_d;
  logic [15:0]      len_new;

  always_ff @(posedge upg_clk_i) begin
    if (upg_rst_i) begin
      state_q <= LD_LEN_LO;
      len_q   <= '0;
      idx_q   <= '0;
      lane_q  <= '0;
      sh_q    <= '0;
      wen_q   <= 1'b0;
      adr_q   <= '0;
      dat_q   <= '0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      idx_q   <= idx_d;
      lane_q  <= lane_d;
      sh_q    <= sh_d;
      wen_q   <= wen_d;
      adr_q   <= adr_d;
      dat_q   <= dat_d;
    end
  end

  assign len_new = {byte_dat, len_q[7:0]};

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    idx_d   = idx_q;
    lane_d  = lane_q;
    sh_d    = sh_q;
    wen_d   = 1'b0;
    adr_d   = adr_q;
    dat_d   = dat_q;
    case (state_q)
      LD_LEN_LO: begin
        if (byte_vld) begin
          len_d   = {8'h00, byte_dat};
          state_d = LD_LEN_HI;
        end
      end
      LD_LEN_HI: begin
        if (byte_vld) begin
          len_d  = len_new;
          idx_d  = '0;
          lane_d = '0;
          if (len_new == 16'd0)                 state_d = LD_DONE;
          else if (32'(len_new) > MAX_WORDS)    state_d = LD_ERR;
          else                                  state_d = LD_DATA;
        end
      end
      LD_DATA: begin
        if (byte_vld) begin
          lane_d = lane_q + 2'd1;
          // Bytes enter at the top and shift down, leaving b0 in the low lane.
          sh_d   = {byte_dat, sh_q[23:8]};
          if (lane_q == 2'd3) begin
            wen_d = 1'b1;
            dat_d = {byte_dat, sh_q};
            adr_d = idx_q[ADR_W-1:0];
          end
        end
        if (wen_q) begin
          idx_d = idx_q + 1'b1;
          if (32'(idx_q) + 32'd1 == 32'(len_q)) state_d = LD_DONE;
        end
      end
      LD_DONE: ;
      LD_ERR:  ;
      default: state_d = LD_ERR;
    endcase
    if (frm_err && state_q != LD_DONE) state_d = LD_ERR;
  end

  assign upg_wen_o  = wen_q;
  assign upg_adr_o  = adr_q;
  assign upg_dat_o  = dat_q;
  assign upg_done_o = (state_q == LD_DONE);
  assign upg_err_o  = (state_q == LD_ERR);

endmodule

// File: tb/tb_uart_prog_loader.sv
// tb/tb_uart_prog_loader.sv - self-checking bench for uart_prog_loader
module tb_uart_prog_loader;

  localparam int CPB   = 8;
  localparam int ADR_W = 14;
  localparam int MAXW  = 16384;

  typedef logic [7:0] u8_q_t[$];

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             rx  = 1'b1;
  logic             wen;
  logic [ADR_W-1:0] adr;
  logic [31:0]      dat;
  logic             done;
  logic             err;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;

  logic [ADR_W-1:0] obs_adr[$];
  logic [31:0]      obs_dat[$];
  int               obs_cyc[$];
  int               start_cyc[$];
  bit               done_seen;
  int               done_cyc;

  uart_prog_loader #(.CLKS_PER_BIT(CPB), .ADR_W(ADR_W), .MAX_WORDS(MAXW)) dut (
    .upg_clk_i  (clk),
    .upg_rst_i  (rst),
    .upg_rx_i   (rx),
    .upg_wen_o  (wen),
    .upg_adr_o  (adr),
    .upg_dat_o  (dat),
    .upg_done_o (done),
    .upg_err_o  (err)
  );

  always #50 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!rst) begin
      if (wen) begin
        obs_adr.push_back(adr);
        obs_dat.push_back(dat);
        obs_cyc.push_back(cyc);
      end
      if (done && !done_seen) begin
        done_seen = 1'b1;
        done_cyc  = cyc;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    start_cyc.push_back(cyc);
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    rx = stop_bit;
    repeat (CPB) @(negedge clk);
    rx = 1'b1;
    repeat ($urandom_range(2, 12)) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    rx  = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    obs_adr.delete();
    obs_dat.delete();
    obs_cyc.delete();
    start_cyc.delete();
    done_seen = 1'b0;
    done_cyc  = 0;
    check("rst_wen",  {31'd0, wen},  32'd0);
    check("rst_adr",  32'(adr),      32'd0);
    check("rst_dat",  dat,           32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_err",  {31'd0, err},  32'd0);
  endtask

  // Reference: the stream before the first bad frame defines the outcome.
  task automatic run_case(input u8_q_t bytes, input int bad_idx, input bit glitch);
    int  plen, n, nwr, bi;
    bit  has_bad, exp_done, exp_err;
    logic [31:0] exp_word;
    do_reset();
    if (glitch) begin
      rx = 1'b0;
      repeat (2) @(negedge clk);
      rx = 1'b1;
      repeat (30) @(negedge clk);
    end
    for (int i = 0; i < bytes.size(); i++)
      send_byte(bytes[i], (i == bad_idx) ? 1'b0 : 1'b1);
    repeat (40) @(negedge clk);

    has_bad  = (bad_idx >= 0) && (bad_idx < bytes.size());
    plen     = has_bad ? bad_idx : bytes.size();
    n        = 0;
    nwr      = 0;
    exp_done = 1'b0;
    exp_err  = 1'b0;
    if (plen < 2) begin
      exp_err = has_bad;
    end else begin
      n = int'(bytes[0]) + 256 * int'(bytes[1]);
      if (n == 0) exp_done = 1'b1;
      else if (n > MAXW) exp_err = 1'b1;
      else begin
        nwr = (plen - 2) / 4;
        if (nwr > n) nwr = n;
        if (nwr == n) exp_done = 1'b1;
        else exp_err = has_bad;
      end
    end

    check("n_writes", 32'(obs_adr.size()), 32'(nwr));
    for (int k = 0; k < nwr && k < obs_adr.size(); k++) begin
      bi = 2 + 4 * k;
      exp_word = {bytes[bi+3], bytes[bi+2], bytes[bi+1], bytes[bi]};
      check("wr_adr", 32'(obs_adr[k]), 32'(k));
      check("wr_dat", obs_dat[k], exp_word);
      check("wr_lat", 32'((obs_cyc[k] >= start_cyc[bi+3] + 76) &&
                          (obs_cyc[k] <= start_cyc[bi+3] + 84)), 32'd1);
    end
    check("done", {31'd0, done}, {31'd0, exp_done});
    check("err",  {31'd0, err},  {31'd0, exp_err});
    if (exp_done && nwr > 0 && obs_cyc.size() == nwr)
      check("done_lat", 32'(done_cyc), 32'(obs_cyc[nwr-1] + 1));
    if (exp_done && n == 0 && plen >= 2)
      check("done0_lat", 32'((done_cyc >= start_cyc[1] + 76) &&
                             (done_cyc <= start_cyc[1] + 84)), 32'd1);
  endtask

  initial begin
    u8_q_t b;
    int    nw, bad;

    do_reset();
    repeat (1000) @(negedge clk);
    check("idle_writes", 32'(obs_adr.size()), 32'd0);
    check("idle_done",   {31'd0, done}, 32'd0);

    b = '{8'h02, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
    run_case(b, -1, 1'b0);

    b = '{8'h00, 8'h00, 8'hAA};
    run_case(b, -1, 1'b0);

    b = '{8'h01, 8'h00, 8'h11, 8'h22, 8'h55};
    run_case(b, 4, 1'b0);

    b = '{8'h01, 8'h40};
    run_case(b, -1, 1'b0);

    b = '{8'h00, 8'h40, 8'h01, 8'h02, 8'h03, 8'h04};
    run_case(b, -1, 1'b0);

    b = '{8'h01, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12};
    run_case(b, -1, 1'b1);

    // Partial word, then reset inside run_case before the replay.
    send_byte(8'h01, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h78, 1'b1);
    send_byte(8'h56, 1'b1);
    run_case(b, -1, 1'b0);

    for (int it = 0; it < 6; it++) begin
      b.delete();
      nw = $urandom_range(1, 3);
      b.push_back(8'(nw));
      b.push_back(8'h00);
      for (int j = 0; j < 4 * nw; j++) b.push_back(8'($urandom_range(0, 255)));
      bad = ($urandom_range(0, 2) == 0) ? $urandom_range(0, b.size() - 1) : -1;
      run_case(b, bad, 1'($urandom_range(0, 1)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_prog_loader.md
# uart_prog_loader

Upstream feeder of the program ROM's UART-programmer port. Receives a serial byte stream on `upg_rx_i` (8N1, LSB first) and parses a length header plus little-endian 32-bit words. Emits one ROM write per word, then raises `upg_done_i`-level completion so the ROM returns to fetch mode. Runs entirely in the 10 MHz UPG clock domain.

## Interface
- `CLKS_PER_BIT`, 87, UPG clock cycles per UART bit (10 MHz / 115200); must be ≥ 4.
- `ADR_W`, 14, ROM word-address width.
- `MAX_WORDS`, 16384, largest accepted word count.

- `upg_clk_i` in 1: UPG clock, 10 MHz. This is the single clock.
- `upg_rst_i` in 1: reset, synchronous, active-high.
- `upg_rx_i` in 1: asynchronous UART line; idles high.
- `upg_wen_o` out 1: one-cycle ROM write strobe.
- `upg_adr_o` out ADR_W: ROM word address. Words, not bytes; no /4 is applied.
- `upg_dat_o` out 32: ROM write data.
- `upg_done_o` out 1: image fully written. Sticky until reset.
- `upg_err_o` out 1: protocol or framing error. Sticky until reset.

## Operation
- Reset values: `upg_wen_o` 0, `upg_adr_o` 0, `upg_dat_o` 0, `upg_done_o` 0, `upg_err_o` 0. Loader FSM goes to LEN_LO; the receiver goes to IDLE.
- Reset mid-operation drops any partial byte or word. The word counter clears and no write is issued.
- Receiver:
  - `upg_rx_i` passes through a 2-FF synchronizer.
  - IDLE waits for a low level, then counts CLKS_PER_BIT/2 (floor) and re-samples.
  - If the re-sample is high, the low was a glitch: return to IDLE with no byte.
  - Otherwise take 8 data bits, one every CLKS_PER_BIT, LSB first, then the stop bit.
  - Stop bit = 1: one-cycle `byte_vld` with the byte.
  - Stop bit = 0: one-cycle `frm_err`, no `byte_vld`.
  - The receiver re-enters IDLE at the stop-bit sample point.
- Loader FSM: LEN_LO → LEN_HI → DATA → DONE, plus a terminal ERR state.
  - LEN_LO: byte → N[7:0].
  - LEN_HI: byte → N[15:8]. If N = 0, go to DONE. If N > MAX_WORDS, go to ERR. Otherwise go to DATA with word index 0 and byte lane 0.
  - DATA: bytes fill lanes 0..3 little-endian, so data = {b3,b2,b1,b0}.
    - On lane 3, the next cycle drives `upg_wen_o` = 1 with `upg_dat_o` = word and `upg_adr_o` = index.
    - The index increments after the strobe. `upg_adr_o`/`upg_dat_o` hold until the next write.
    - After the strobe for word N−1, go to DONE.
  - DONE: `upg_done_o` = 1. Further bytes are ignored.
  - ERR: `upg_err_o` = 1 and `upg_done_o` stays 0. Further bytes are ignored.
- `frm_err` in any state other than DONE sends the FSM to ERR.
- Index arithmetic is ADR_W+1 bits wide, so N = MAX_WORDS never wraps the address.

## Timing
- Synchronizer adds 2 cycles.
- `byte_vld` fires at start-edge-seen + CLKS_PER_BIT/2 + 9·CLKS_PER_BIT cycles.
- `upg_wen_o` rises exactly 1 cycle after the `byte_vld` of a word's 4th byte.
- `upg_done_o` rises:
  - in the cycle after the last `upg_wen_o` pulse, or
  - 1 cycle after the LEN_HI `byte_vld` when N = 0.
- `upg_err_o` rises 1 cycle after the offending `frm_err` or LEN_HI byte.
- At most one write per 40·CLKS_PER_BIT cycles, so the ROM needs no backpressure.

## Structure
- Shared package `upg_pkg`:
  - loader state enum (LEN_LO, LEN_HI, DATA, DONE, ERR);
  - receiver state enum (IDLE, START, DATA, STOP);
  - default `CLKS_PER_BIT`;
  - `UPG_ADR_W` = 14.
- Sub-module `uart_rx_byte`: synchronizer, bit timer, shift register, `byte_vld`/`frm_err`. The top holds the loader FSM, lane/word counters and output registers.

## Test plan
All scenarios use CLKS_PER_BIT = 8.
- Reset with the line idle: all outputs 0. After 1000 idle cycles, no `upg_wen_o` pulse.
- Send 02 00, then 78 56 34 12, then EF BE AD DE:
  - first strobe: adr 0, dat 0x12345678;
  - second strobe: adr 1, dat 0xDEADBEEF;
  - `upg_done_o` = 1 the cycle after the second strobe.
- Send 00 00: no strobe, `upg_done_o` = 1 one cycle after the 2nd byte. A following byte AA causes no strobe.
- Send 01 00 and 11 22, then a frame with stop bit 0: `upg_err_o` = 1, `upg_done_o` = 0, no strobe.
- Send 01 40 (N = 16385 > MAX_WORDS): `upg_err_o` = 1 and no strobes.
- Glitches and reset:
  - A 2-cycle low glitch produces no byte.
  - Assert `upg_rst_i` after 2 data bytes of word 0, then replay 01 00 78 56 34 12: a single strobe at adr 0, dat 0x12345678.
